// File: rtl/mem_pattern_master.sv
`timescale 1ns/1ps
// Memory pattern master: writes (seed + offset) to a run of words, reads them back and counts mismatches.
// Latency: one request per 3 cycles with a one-cycle-late ready; done_o is visible 6*len cycles after start.
// Backpressure: request held stable while ready_i=0; a request stalled TIMEOUT cycles aborts the run.
module mem_pattern_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_GAP = 3'd2;
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         len_q;
    logic [WIDTH-1:0]      seed_q;
    logic [CW-1:0]         offset;
    logic [WW-1:0]         wait_cnt;

    logic [CW-1:0]         addr_sum;
    logic                  xfer;
    logic                  last;
    logic                  mismatch;
    logic                  stall_out;

    // Request address wraps modulo DEPTH (base and offset are both below DEPTH, so one subtract suffices)
    always_comb begin
        addr_sum = {1'b0, base_q} + offset;
        if (addr_sum >= DEPTH_C) begin
            addr_o = ADDR_WIDTH'(addr_sum - DEPTH_C);
        end else begin
            addr_o = ADDR_WIDTH'(addr_sum);
        end
    end

    assign wdata_o   = seed_q + WIDTH'(offset);
    assign valid_o   = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign wr_rd_o   = (state == S_WR_REQ);
    assign busy_o    = (state != S_IDLE);
    assign done_o    = (state == S_FIN);
    assign xfer      = valid_o && ready_i;
    assign last      = (offset == len_q - 1'b1);
    assign mismatch  = (rdata_i != wdata_o);
    assign stall_out = !ready_i && (wait_cnt == WAIT_LAST);

    // Run sequencer: latches the run, steps write then read phases, accumulates status
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= S_IDLE;
            base_q           <= '0;
            len_q            <= '0;
            seed_q           <= '0;
            offset           <= '0;
            wait_cnt         <= '0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        base_q           <= base_addr_i;
                        seed_q           <= seed_i;
                        len_q            <= (len_i > DEPTH_C) ? DEPTH_C : len_i;
                        offset           <= '0;
                        wait_cnt         <= '0;
                        timeout_o        <= 1'b0;
                        err_count_o      <= '0;
                        first_err_addr_o <= '0;
                        if (len_i == '0) begin
                            state  <= S_FIN;
                            pass_o <= 1'b1;
                        end else begin
                            state  <= S_WR_REQ;
                            pass_o <= 1'b0;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (xfer) begin
                        offset   <= offset + 1'b1;
                        wait_cnt <= '0;
                        state    <= S_WR_GAP;
                    end else if (stall_out) begin
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        state     <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WR_GAP: begin
                    if (offset == len_q) begin
                        offset <= '0;
                        state  <= S_RD_REQ;
                    end else begin
                        state  <= S_WR_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (xfer) begin
                        offset   <= offset + 1'b1;
                        wait_cnt <= '0;
                        if (mismatch) begin
                            err_count_o <= err_count_o + 1'b1;
                            if (err_count_o == '0) begin
                                first_err_addr_o <= addr_o;
                            end
                        end
                        if (last) begin
                            pass_o <= (err_count_o == '0) && !mismatch;
                            state  <= S_FIN;
                        end else begin
                            state  <= S_RD_GAP;
                        end
                    end else if (stall_out) begin
                        timeout_o <= 1'b1;
                        pass_o    <= 1'b0;
                        state     <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RD_GAP: begin
                    state <= S_RD_REQ;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_pattern_master.sv
`timescale 1ns/1ps
// Directed bench for mem_pattern_master with a one-cycle-late responsive memory model.
module tb_mem_pattern_master;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  base_addr_i = '0;
    logic [6:0]  len_i = '0;
    logic [15:0] seed_i = '0;
    logic        valid_o;
    logic [5:0]  addr_o;
    logic [15:0] wdata_o;
    logic        wr_rd_o;
    logic        ready_i;
    logic [15:0] rdata_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        timeout_o;
    logic [6:0]  err_count_o;
    logic [5:0]  first_err_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model controls
    logic        mem_en = 1'b1;
    int          corr_a = -1;
    int          corr_b = -1;
    logic        wait_done_r = 1'b0;
    logic [15:0] mem [64];

    // observation logs (monotonic, tasks take deltas)
    int wa_q[$];
    int wd_q[$];
    int ra_q[$];
    int vcount = 0;
    int dcount = 0;

    mem_pattern_master #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .seed_i(seed_i),
        .valid_o(valid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o),
        .ready_i(ready_i), .rdata_i(rdata_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    assign ready_i = mem_en && valid_o && wait_done_r;
    assign rdata_i = (int'(addr_o) == corr_a || int'(addr_o) == corr_b) ? ~mem[addr_o] : mem[addr_o];

    always @(posedge clk_i) begin
        if (reset_i) wait_done_r <= 1'b0;
        else         wait_done_r <= valid_o && !ready_i;
        if (valid_o) vcount <= vcount + 1;
        if (done_o)  dcount <= dcount + 1;
        if (valid_o && ready_i) begin
            if (wr_rd_o) begin
                mem[addr_o] <= wdata_o;
                wa_q.push_back(int'(addr_o));
                wd_q.push_back(int'(wdata_o));
            end else begin
                ra_q.push_back(int'(addr_o));
            end
        end
    end

    task automatic launch(input logic [5:0] b, input logic [6:0] l, input logic [15:0] s);
        @(negedge clk_i);
        base_addr_i = b;
        len_i       = l;
        seed_i      = s;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!done_o && cyc < limit);
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_checks++; if ({pass_o, timeout_o} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", {pass_o, timeout_o}); end
        n_checks++; if ({err_count_o, first_err_addr_o, addr_o, wdata_o, wr_rd_o} !== 36'h0) begin
            n_fail++; $display("FAIL reset_vectors: err=%0d fea=%0d addr=%0d wd=%h wr=%b want all 0",
                               err_count_o, first_err_addr_o, addr_o, wdata_o, wr_rd_o);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_basic;
        int cyc, w0, r0, v0;
        w0 = wa_q.size(); r0 = ra_q.size(); v0 = vcount;
        launch(6'd0, 7'd4, 16'h0100);
        wait_done(60, cyc);
        n_checks++; if (cyc !== 24) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 24", cyc); end
        n_checks++; if (pass_o !== 1'b1) begin n_fail++; $display("FAIL basic_pass: got %b want 1", pass_o); end
        n_checks++; if (err_count_o !== 7'd0) begin n_fail++; $display("FAIL basic_errs: got %0d want 0", err_count_o); end
        n_checks++; if (wa_q.size() - w0 !== 4 || ra_q.size() - r0 !== 4) begin
            n_fail++; $display("FAIL basic_counts: writes %0d reads %0d want 4 4", wa_q.size() - w0, ra_q.size() - r0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wa_q[w0+k] !== k || wd_q[w0+k] !== 32'h0100 + k || ra_q[r0+k] !== k) begin
                    n_fail++; $display("FAIL basic_xfer%0d: wa=%0d wd=%h ra=%0d want %0d %h %0d",
                                       k, wa_q[w0+k], wd_q[w0+k], ra_q[r0+k], k, 32'h0100 + k, k);
                end
            end
        end
        n_checks++; if (vcount - v0 !== 16) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 16", vcount - v0); end
        @(negedge clk_i);
        n_checks++; if ({done_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: done/busy got %b want 00", {done_o, busy_o}); end
    endtask

    task automatic test_wrap;
        int cyc, w0, r0;
        int exp_a[4] = '{62, 63, 0, 1};
        w0 = wa_q.size(); r0 = ra_q.size();
        launch(6'd62, 7'd4, 16'hABCD);
        wait_done(60, cyc);
        n_checks++; if (cyc !== 24 || pass_o !== 1'b1) begin n_fail++; $display("FAIL wrap_done: cyc=%0d pass=%b want 24 1", cyc, pass_o); end
        n_checks++; if (wa_q.size() - w0 !== 4 || ra_q.size() - r0 !== 4) begin
            n_fail++; $display("FAIL wrap_counts: writes %0d reads %0d want 4 4", wa_q.size() - w0, ra_q.size() - r0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wa_q[w0+k] !== exp_a[k] || ra_q[r0+k] !== exp_a[k] || wd_q[w0+k] !== 32'hABCD + k) begin
                    n_fail++; $display("FAIL wrap_addr%0d: wa=%0d ra=%0d wd=%h want %0d %0d %h",
                                       k, wa_q[w0+k], ra_q[r0+k], wd_q[w0+k], exp_a[k], exp_a[k], 32'hABCD + k);
                end
            end
        end
    endtask

    task automatic test_errors;
        int cyc;
        corr_a = 5; corr_b = 7;
        launch(6'd4, 7'd4, 16'h2222);
        wait_done(60, cyc);
        n_checks++; if (cyc !== 24) begin n_fail++; $display("FAIL err_done_cycle: got %0d want 24", cyc); end
        n_checks++; if (err_count_o !== 7'd2) begin n_fail++; $display("FAIL err_count: got %0d want 2", err_count_o); end
        n_checks++; if (first_err_addr_o !== 6'd5) begin n_fail++; $display("FAIL err_first_addr: got %0d want 5", first_err_addr_o); end
        n_checks++; if (pass_o !== 1'b0) begin n_fail++; $display("FAIL err_pass: got %b want 0", pass_o); end
        corr_a = -1; corr_b = -1;
        repeat (5) @(negedge clk_i);
        n_checks++; if ({err_count_o, first_err_addr_o, pass_o, timeout_o} !== {7'd2, 6'd5, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL err_hold: err=%0d fea=%0d pass=%b to=%b want 2 5 0 0", err_count_o, first_err_addr_o, pass_o, timeout_o);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        logic stable;
        int v0, w0;
        stable = 1'b1;
        mem_en = 1'b0;
        v0 = vcount; w0 = wa_q.size();
        launch(6'd9, 7'd3, 16'h7000);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
            if (valid_o && (addr_o !== 6'd9 || wdata_o !== 16'h7000 || wr_rd_o !== 1'b1)) stable = 1'b0;
        end while (!done_o && cyc < 60);
        n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL to_done_cycle: got %0d want 17", cyc); end
        n_checks++; if (vcount - v0 !== 16) begin n_fail++; $display("FAIL to_valid_cycles: got %0d want 16", vcount - v0); end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL to_req_stable: got %b want 1", stable); end
        n_checks++; if ({timeout_o, pass_o} !== 2'b10) begin n_fail++; $display("FAIL to_status: to/pass got %b want 10", {timeout_o, pass_o}); end
        n_checks++; if (wa_q.size() - w0 !== 0) begin n_fail++; $display("FAIL to_no_write: got %0d want 0", wa_q.size() - w0); end
        @(negedge clk_i);
        n_checks++; if ({busy_o, done_o, timeout_o} !== 3'b001) begin n_fail++; $display("FAIL to_after: busy/done/to got %b want 001", {busy_o, done_o, timeout_o}); end
        mem_en = 1'b1;
    endtask

    task automatic test_len0;
        int cyc, v0;
        v0 = vcount;
        launch(6'd3, 7'd0, 16'h1234);
        wait_done(20, cyc);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d want 1", cyc); end
        n_checks++; if (pass_o !== 1'b1) begin n_fail++; $display("FAIL len0_pass: got %b want 1", pass_o); end
        repeat (2) @(negedge clk_i);
        n_checks++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL len0_no_valid: got %0d want 0", vcount - v0); end
    endtask

    task automatic test_clamp;
        int cyc, w0, r0;
        w0 = wa_q.size(); r0 = ra_q.size();
        launch(6'd0, 7'd100, 16'h0000);
        wait_done(1000, cyc);
        n_checks++; if (cyc !== 384) begin n_fail++; $display("FAIL clamp_done_cycle: got %0d want 384", cyc); end
        n_checks++; if (wa_q.size() - w0 !== 64 || ra_q.size() - r0 !== 64) begin
            n_fail++; $display("FAIL clamp_counts: writes %0d reads %0d want 64 64", wa_q.size() - w0, ra_q.size() - r0);
        end
        n_checks++; if (wa_q[$] !== 63 || wd_q[$] !== 63 || pass_o !== 1'b1) begin
            n_fail++; $display("FAIL clamp_last: wa=%0d wd=%0d pass=%b want 63 63 1", wa_q[$], wd_q[$], pass_o);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc, w0;
        w0 = wa_q.size();
        launch(6'd10, 7'd2, 16'h5000);
        @(negedge clk_i);
        base_addr_i = 6'd20; len_i = 7'd4; start_i = 1'b1;
        repeat (2) @(negedge clk_i);
        start_i = 1'b0;
        wait_done(60, cyc);
        cyc = cyc + 3;
        n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL busy_done_cycle: got %0d want 12", cyc); end
        n_checks++; if (wa_q.size() - w0 !== 2 || wa_q[$] !== 11 || pass_o !== 1'b1) begin
            n_fail++; $display("FAIL busy_ignore: writes %0d last %0d pass %b want 2 11 1", wa_q.size() - w0, wa_q[$], pass_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_midrun;
        int cyc, d0;
        launch(6'd0, 7'd4, 16'h0100);
        cyc = 0;
        while (!(valid_o && !wr_rd_o) && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
        end
        n_checks++; if (valid_o !== 1'b1 || wr_rd_o !== 1'b0) begin n_fail++; $display("FAIL mid_reach_rd: valid/wr got %b want 10", {valid_o, wr_rd_o}); end
        d0 = dcount;
        reset_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if ({valid_o, busy_o, done_o, pass_o, timeout_o, wr_rd_o} !== 6'b0) begin
            n_fail++; $display("FAIL mid_reset_ctl: v/b/d/p/t/w got %b want 000000", {valid_o, busy_o, done_o, pass_o, timeout_o, wr_rd_o});
        end
        n_checks++; if ({err_count_o, first_err_addr_o, addr_o, wdata_o} !== 35'h0) begin
            n_fail++; $display("FAIL mid_reset_vec: err=%0d fea=%0d addr=%0d wd=%h want 0", err_count_o, first_err_addr_o, addr_o, wdata_o);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (dcount - d0 !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", dcount - d0); end
        launch(6'd30, 7'd3, 16'h0F00);
        wait_done(60, cyc);
        n_checks++; if (cyc !== 18 || pass_o !== 1'b1) begin n_fail++; $display("FAIL mid_rerun: cyc=%0d pass=%b want 18 1", cyc, pass_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_errors();
        test_timeout();
        test_len0();
        test_clamp();
        test_busy_ignore();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
